// File: rtl/ttc_pkg.sv
// Shared TTC link definitions: header/frame codes, deframer states and command decode.
package ttc_pkg;

    localparam int unsigned PAIR_W = 2;
    localparam int unsigned CMD_W  = 4;

    localparam logic [PAIR_W-1:0] TTC_HDR  = 2'b11;
    localparam logic [PAIR_W-1:0] TTC_IDLE = 2'b00;

    // Frame codes are {p1,p2}
    localparam logic [CMD_W-1:0] CMD_BCR  = 4'b1100;
    localparam logic [CMD_W-1:0] CMD_TRIG = 4'b0000;
    localparam logic [CMD_W-1:0] CMD_ER   = 4'b1111;
    localparam logic [CMD_W-1:0] CMD_MR   = 4'b0011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_P1   = 2'd1,
        ST_P2   = 2'd2
    } rx_state_t;

    typedef struct packed {
        logic bcr;
        logic trig;
        logic er;
        logic mr;
    } ttc_cmd_t;

    function automatic logic is_cmd(input logic [CMD_W-1:0] code);
        return (code == CMD_BCR) || (code == CMD_TRIG) ||
               (code == CMD_ER)  || (code == CMD_MR);
    endfunction

    function automatic ttc_cmd_t decode_cmd(input logic [CMD_W-1:0] code);
        ttc_cmd_t c;
        c      = '0;
        c.bcr  = (code == CMD_BCR);
        c.trig = (code == CMD_TRIG);
        c.er   = (code == CMD_ER);
        c.mr   = (code == CMD_MR);
        return c;
    endfunction

endpackage

// File: rtl/ttc_frame_rx.sv
// TTC deframer: finds 11 headers, captures the two payload pairs and flags malformed frames.
// Outputs are combinational and valid in the cycle the second payload pair is on the link.
module ttc_frame_rx
    import ttc_pkg::*;
(
    input  logic              clk_40,
    input  logic              rst_40,
    input  logic [PAIR_W-1:0] encode_ttc,
    input  logic              enable,
    output logic              cmd_valid,
    output logic [CMD_W-1:0]  cmd,
    output logic              frame_err_raw
);

    rx_state_t         state;
    rx_state_t         state_nxt;
    logic [PAIR_W-1:0] p1_q;
    logic [PAIR_W-1:0] p1_nxt;

    always_ff @(posedge clk_40) begin
        if (rst_40) begin
            state <= ST_IDLE;
            p1_q  <= '0;
        end else begin
            state <= state_nxt;
            p1_q  <= p1_nxt;
        end
    end

    // P2 always returns to IDLE so a header right after p2 opens the next frame
    always_comb begin
        state_nxt     = state;
        p1_nxt        = p1_q;
        cmd_valid     = 1'b0;
        cmd           = {p1_q, encode_ttc};
        frame_err_raw = 1'b0;
        if (!enable) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (encode_ttc == TTC_HDR) begin
                        state_nxt = ST_P1;
                    end else if (encode_ttc != TTC_IDLE) begin
                        frame_err_raw = 1'b1;
                    end
                end
                ST_P1: begin
                    p1_nxt    = encode_ttc;
                    state_nxt = ST_P2;
                end
                ST_P2: begin
                    state_nxt = ST_IDLE;
                    if (is_cmd(cmd)) begin
                        cmd_valid = 1'b1;
                    end else begin
                        frame_err_raw = 1'b1;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ttc_decoder.sv
// TTC stream decoder: command pulses, BCID/event-ID counters, trigger tagging and error count.
module ttc_decoder
    import ttc_pkg::*;
#(
    parameter int unsigned BC_MAX     = 3563,
    parameter int unsigned BCR_OFFSET = 0,
    parameter int unsigned BCID_W     = 12,
    parameter int unsigned EVID_W     = 12,
    parameter int unsigned ERR_W      = 8
) (
    input  logic              clk_40,
    input  logic              rst_40,
    input  logic [PAIR_W-1:0] encode_ttc,
    input  logic              enable,
    output logic              bcr,
    output logic              trigger,
    output logic              event_reset,
    output logic              master_reset,
    output logic [BCID_W-1:0] bcid,
    output logic [EVID_W-1:0] evid,
    output logic [BCID_W-1:0] trig_bcid,
    output logic [EVID_W-1:0] trig_evid,
    output logic              bcid_valid,
    output logic              frame_err,
    output logic [ERR_W-1:0]  err_count
);

    logic              cmd_valid;
    logic [CMD_W-1:0]  cmd;
    logic              frame_err_raw;
    ttc_cmd_t          dec;
    logic [BCID_W-1:0] bcid_nxt;
    logic [EVID_W-1:0] evid_nxt;
    logic [ERR_W-1:0]  err_nxt;

    ttc_frame_rx u_frame_rx (
        .clk_40        (clk_40),
        .rst_40        (rst_40),
        .encode_ttc    (encode_ttc),
        .enable        (enable),
        .cmd_valid     (cmd_valid),
        .cmd           (cmd),
        .frame_err_raw (frame_err_raw)
    );

    assign dec = cmd_valid ? decode_cmd(cmd) : '0;

    // BCR load wins over wrap; MR and BCR never coincide
    always_comb begin
        bcid_nxt = (bcid == BCID_W'(BC_MAX)) ? '0 : bcid + BCID_W'(1);
        if (dec.mr) begin
            bcid_nxt = '0;
        end
        if (dec.bcr) begin
            bcid_nxt = BCID_W'(BCR_OFFSET);
        end

        evid_nxt = evid;
        if (dec.trig) begin
            evid_nxt = evid + EVID_W'(1);
        end
        if (dec.er || dec.mr) begin
            evid_nxt = '0;
        end

        err_nxt = err_count;
        if (frame_err_raw && (err_count != {ERR_W{1'b1}})) begin
            err_nxt = err_count + ERR_W'(1);
        end
        if (dec.mr) begin
            err_nxt = '0;
        end
    end

    always_ff @(posedge clk_40) begin
        if (rst_40) begin
            bcr          <= 1'b0;
            trigger      <= 1'b0;
            event_reset  <= 1'b0;
            master_reset <= 1'b0;
            bcid         <= '0;
            evid         <= '0;
            trig_bcid    <= '0;
            trig_evid    <= '0;
            bcid_valid   <= 1'b0;
            frame_err    <= 1'b0;
            err_count    <= '0;
        end else begin
            bcr          <= dec.bcr;
            trigger      <= dec.trig;
            event_reset  <= dec.er;
            master_reset <= dec.mr;
            frame_err    <= frame_err_raw;
            bcid         <= bcid_nxt;
            evid         <= evid_nxt;
            err_count    <= err_nxt;
            if (dec.trig) begin
                trig_bcid <= bcid;
                trig_evid <= evid;
            end
            if (dec.mr) begin
                bcid_valid <= 1'b0;
            end else if (dec.bcr) begin
                bcid_valid <= 1'b1;
            end
        end
    end

endmodule
